// File: rtl/seg7_pkg.sv
// Shared definitions for the 7-segment scan controller: the scan state
// enum, segment bit positions and the hex-to-segment table.
package seg7_pkg;

   // Each digit slot is a dark BLANK lead-in followed by a DRIVE period.
   typedef enum logic {
      ST_BLANK = 1'b0,
      ST_DRIVE = 1'b1
   } scan_state_e;

   // Segment bit order on seg_out: {a,b,c,d,e,f,g}, a in the MSB.
   localparam int SEG_A = 6;
   localparam int SEG_B = 5;
   localparam int SEG_C = 4;
   localparam int SEG_D = 3;
   localparam int SEG_E = 2;
   localparam int SEG_F = 1;
   localparam int SEG_G = 0;

   // Active-high segment patterns; entry 0 is the rightmost element.
   localparam logic [15:0][6:0] SEG_TABLE = {
      7'h47, 7'h4F, 7'h3D, 7'h4E,   // F E D C
      7'h1F, 7'h77, 7'h7B, 7'h7F,   // B A 9 8
      7'h70, 7'h5F, 7'h5B, 7'h33,   // 7 6 5 4
      7'h79, 7'h6D, 7'h30, 7'h7E    // 3 2 1 0
   };

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Load port of the scan controller.
// Handshake: the producer raises load_valid with load_data and holds both
// stable until a rising clk edge on which load_valid && load_ready; that
// edge is the transfer. load_ready never depends on load_valid.
interface seg7_scan_ctrl_if #(
   parameter int NUM_DIGITS = 4
);
   logic                      load_valid;
   logic                      load_ready;
   logic [4*NUM_DIGITS-1:0]   load_data;

   modport master (output load_valid, output load_data, input load_ready);
   modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder (one shared instance).
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   // Table lookup of the segment pattern for the nibble.
   always_comb begin
      seg = SEG_TABLE[nibble];
   end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed scan controller for a multi-digit 7-segment display.
// Each digit slot is BLANK_CYC dark cycles then a DRIVE period; the
// display value is double-buffered so loads only land at frame boundaries.
// Optional build macro SEG7_LZ_SUPPRESS_EN enables leading-zero blanking.
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int SLOT_CYC   = 1000,
   parameter int BLANK_CYC  = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   seg7_scan_ctrl_if.slave       load_if,
   input  logic [NUM_DIGITS-1:0] blank_mask,
   output logic [6:0]            seg_out,
   output logic [NUM_DIGITS-1:0] dig_en,
   output logic                  frame_start,
   output scan_state_e           dbg_state
);

   localparam int CNT_W = (SLOT_CYC > 2) ? $clog2(SLOT_CYC) : 1;
   localparam int DIG_W = $clog2(NUM_DIGITS);
   localparam int DAT_W = 4 * NUM_DIGITS;
   localparam logic [CNT_W-1:0] CNT_BLANK_END = CNT_W'(BLANK_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_SLOT_END  = CNT_W'(SLOT_CYC - 1);
   localparam logic [DIG_W-1:0] DIG_LAST      = DIG_W'(NUM_DIGITS - 1);

   scan_state_e            state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [DIG_W-1:0]       digit_q, digit_d;
   logic                   started_q, started_d;
   logic [DAT_W-1:0]       pending_q, pending_d;
   logic [DAT_W-1:0]       display_q, display_d;
   logic                   full_q, full_d;
   logic                   ready_q, ready_d;
   logic [6:0]             seg_q, seg_d;
   logic [NUM_DIGITS-1:0]  dig_q, dig_d;
   logic                   fs_q, fs_d;

   logic                   boundary;
   logic                   accept;
   logic                   xfer;
   logic [3:0]             cur_nib;
   logic [6:0]             dec_seg;
   logic                   lz_dark;

   assign accept = load_if.load_valid && ready_q;

   // Scan sequencing and the pending/display double buffer.
   always_comb begin
      started_d = 1'b1;
      state_d   = state_q;
      cnt_d     = cnt_q;
      digit_d   = digit_q;
      boundary  = 1'b0;
      pending_d = pending_q;
      display_d = display_q;
      full_d    = full_q;
      xfer      = 1'b0;
      // The first edge after reset only enters BLANK/digit 0/count 0.
      if (!started_q) begin
         boundary = 1'b1;
      end else begin
         cnt_d = (cnt_q == CNT_SLOT_END) ? '0 : cnt_q + 1'b1;
         if (cnt_q == CNT_BLANK_END) begin
            state_d = ST_DRIVE;
         end
         if (cnt_q == CNT_SLOT_END) begin
            state_d = ST_BLANK;
            if (digit_q == DIG_LAST) begin
               digit_d  = '0;
               boundary = 1'b1;
            end else begin
               digit_d = digit_q + 1'b1;
            end
         end
      end
      if (boundary) begin
         if (full_q) begin
            display_d = pending_q;
            full_d    = 1'b0;
            xfer      = 1'b1;
         end else if (accept) begin
            display_d = load_if.load_data;
         end
      end else if (accept) begin
         pending_d = load_if.load_data;
         full_d    = 1'b1;
      end
      // Ready returns one cycle after a transfer edge, not on it.
      ready_d = !full_d && !xfer;
   end

   assign cur_nib = display_d[{digit_d, 2'b00} +: 4];

   seg7_hex_decode u_dec (
      .nibble (cur_nib),
      .seg    (dec_seg)
   );

`ifdef SEG7_LZ_SUPPRESS_EN
   logic [DIG_W-1:0] msd;
   // Digits above the most significant nonzero nibble are dark; digit 0 never.
   always_comb begin
      msd = '0;
      for (int i = 1; i < NUM_DIGITS; i++) begin
         if (display_d[4*i +: 4] != 4'h0) msd = DIG_W'(i);
      end
      lz_dark = (digit_d > msd);
   end
`else
   assign lz_dark = 1'b0;
`endif

   // Output values for the cycle that the next state describes.
   always_comb begin
      seg_d = '0;
      dig_d = '0;
      if (state_d == ST_DRIVE && !blank_mask[digit_d] && !lz_dark) begin
         seg_d = dec_seg;
         dig_d = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_d;
      end
      fs_d = (state_d == ST_BLANK) && (digit_d == '0) && (cnt_d == '0);
   end

   // All state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_BLANK;
         cnt_q     <= '0;
         digit_q   <= '0;
         started_q <= 1'b0;
         pending_q <= '0;
         display_q <= '0;
         full_q    <= 1'b0;
         ready_q   <= 1'b1;
         seg_q     <= '0;
         dig_q     <= '0;
         fs_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         digit_q   <= digit_d;
         started_q <= started_d;
         pending_q <= pending_d;
         display_q <= display_d;
         full_q    <= full_d;
         ready_q   <= ready_d;
         seg_q     <= seg_d;
         dig_q     <= dig_d;
         fs_q      <= fs_d;
      end
   end

   assign seg_out            = seg_q;
   assign dig_en             = dig_q;
   assign frame_start        = fs_q;
   assign load_if.load_ready = ready_q;
   assign dbg_state          = state_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Bench for seg7_scan_ctrl with NUM_DIGITS=4, SLOT_CYC=10, BLANK_CYC=2.
// A reference model predicts every cycle's outputs into exp_q; a monitor
// pops and compares on the falling edge. Directed scenarios add spot checks.
module tb_seg7_scan_ctrl;
   import seg7_pkg::*;

   localparam int N     = 4;
   localparam int SLOT  = 10;
   localparam int BLANK = 2;
   localparam int FRAME = N * SLOT;
   localparam int W     = 13;   // {frame_start, load_ready, dig_en, seg_out}
   localparam logic [W-1:0] RST_VEC = {1'b0, 1'b1, 4'b0, 7'b0};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [N-1:0]  blank_mask = '0;
   logic [6:0]    seg_out;
   logic [N-1:0]  dig_en;
   logic          frame_start;
   scan_state_e   dbg_state;

   seg7_scan_ctrl_if #(.NUM_DIGITS(N)) lif ();

   seg7_scan_ctrl #(.NUM_DIGITS(N), .SLOT_CYC(SLOT), .BLANK_CYC(BLANK)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .load_if     (lif.slave),
      .blank_mask  (blank_mask),
      .seg_out     (seg_out),
      .dig_en      (dig_en),
      .frame_start (frame_start),
      .dbg_state   (dbg_state)
   );

   // Clock and reset
   always #5 clk = ~clk;

   int n_total = 0;
   int n_bad   = 0;
   int cyc     = -1;
   logic [W-1:0] exp_q[$];

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s (cycle %0d): got %h want %h", name, cyc, act, exp);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] nib);
      case (nib)
         4'h0: return 7'h7E; 4'h1: return 7'h30; 4'h2: return 7'h6D; 4'h3: return 7'h79;
         4'h4: return 7'h33; 4'h5: return 7'h5B; 4'h6: return 7'h5F; 4'h7: return 7'h70;
         4'h8: return 7'h7F; 4'h9: return 7'h7B; 4'hA: return 7'h77; 4'hB: return 7'h1F;
         4'hC: return 7'h4E; 4'hD: return 7'h3D; 4'hE: return 7'h4F; default: return 7'h47;
      endcase
   endfunction

   // Reference model: cycle number since reset release drives everything.
   int unsigned m_t;
   bit          m_started = 0;
   logic [15:0] m_pend = '0, m_disp = '0;
   bit          m_full = 0, m_ready = 1;

   always @(posedge clk) begin : model
      bit acc, xfer, dark;
      int d, off, msd;
      logic [3:0] nib;
      logic [6:0] e_seg;
      logic [N-1:0] e_dig;
      if (!rst_n) begin
         m_started = 0; m_full = 0; m_ready = 1; m_pend = '0; m_disp = '0;
         exp_q.push_back(RST_VEC);
      end else begin
         acc = lif.load_valid && m_ready;
         if (!m_started) begin m_started = 1; m_t = 0; end
         else m_t++;
         xfer = 0;
         if (m_t % FRAME == 0) begin
            if (m_full) begin m_disp = m_pend; m_full = 0; xfer = 1; end
            else if (acc) m_disp = lif.load_data;
         end else if (acc) begin
            m_pend = lif.load_data; m_full = 1;
         end
         m_ready = !m_full && !xfer;
         d   = (m_t % FRAME) / SLOT;
         off = m_t % SLOT;
         e_seg = '0;
         e_dig = '0;
         if (off >= BLANK) begin
            nib  = m_disp[4*d +: 4];
            dark = blank_mask[d];
`ifdef SEG7_LZ_SUPPRESS_EN
            msd = 0;
            for (int i = 0; i < N; i++) if (m_disp[4*i +: 4] != 4'h0) msd = i;
            if (d > msd) dark = 1;
`endif
            if (!dark) begin e_seg = ref_seg(nib); e_dig = N'(1) << d; end
         end
         exp_q.push_back({(m_t % FRAME == 0), m_ready, e_dig, e_seg});
      end
   end

   // Monitor: one expected entry per cycle, compared mid-cycle.
   initial begin : monitor
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (exp_q.size() == 0) begin
            check("queue_empty", 16'(exp_q.size()), 16'd1);
         end else begin
            e = exp_q.pop_front();
            if (!rst_n) e = RST_VEC;
            check("outputs", 16'({frame_start, lif.load_ready, dig_en, seg_out}), 16'(e));
         end
      end
   end

   // Driver tasks
   task automatic cycle();
      bit hs;
      @(negedge clk);
      hs = lif.load_valid && lif.load_ready;
      @(posedge clk);
      #1;
      if (hs) lif.load_valid = 1'b0;
      cyc++;
   endtask

   task automatic run_to(input int k);
      while (cyc < k) cycle();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      lif.load_valid = 1'b0;
      blank_mask = '0;
      cycle();
      cycle();
      rst_n = 1'b1;
      cyc = -1;
   endtask

   task automatic offer(input logic [15:0] v);
      lif.load_valid = 1'b1;
      lif.load_data  = v;
   endtask

   function automatic logic [15:0] rand_data();
      logic [15:0] v;
      for (int i = 0; i < 4; i++)
         v[4*i +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      return v;
   endfunction

   initial begin : driver
      lif.load_valid = 1'b0;
      lif.load_data  = '0;
      // Scenario 1: reset, no load
      do_reset();
      run_to(0);  check("s1_fs0", 16'(frame_start), 16'd1);
      run_to(1);  check("s1_blank_dig", 16'(dig_en), 16'h0);
      run_to(2);  check("s1_d0_dig", 16'(dig_en), 16'h1);
                  check("s1_d0_seg", 16'(seg_out), 16'h7E);
      run_to(32); check("s1_d3_dig", 16'(dig_en), 16'h8);
      run_to(40); check("s1_fs40", 16'(frame_start), 16'd1);
      run_to(85);

      // Scenario 2: load 1A2F at cycle 5
      do_reset();
      run_to(5);  offer(16'h1A2F);
      run_to(6);  check("s2_ready_drop", 16'(lif.load_ready), 16'd0);
      run_to(12); check("s2_old_seg", 16'(seg_out), 16'h7E);
      run_to(40); check("s2_ready40", 16'(lif.load_ready), 16'd0);
      run_to(41); check("s2_ready41", 16'(lif.load_ready), 16'd1);
      run_to(42); check("s2_d0_seg", 16'(seg_out), 16'h47);
      run_to(52); check("s2_d1_seg", 16'(seg_out), 16'h6D);
      run_to(62); check("s2_d2_seg", 16'(seg_out), 16'h77);
      run_to(72); check("s2_d3_seg", 16'(seg_out), 16'h30);
      run_to(85);

      // Scenario 3: second load held off until the transfer
      do_reset();
      run_to(5);  offer(16'h1111);
      run_to(10); offer(16'h2222);
      run_to(40); check("s3_ready40", 16'(lif.load_ready), 16'd0);
      run_to(42); check("s3_f1_seg", 16'(seg_out), 16'h30);
      run_to(82); check("s3_f2_seg", 16'(seg_out), 16'h6D);
      run_to(90);

      // Scenario 4: load accepted on the boundary edge
      do_reset();
      run_to(39); offer(16'hC0DE);
      run_to(40); check("s4_ready40", 16'(lif.load_ready), 16'd1);
      run_to(42); check("s4_d0_seg", 16'(seg_out), 16'h4F);
      run_to(50);

      // Scenario 5: blank mask and leading zeros
      do_reset();
      blank_mask = 4'b0100;
      run_to(5);  offer(16'h0030);
      run_to(13); check("s5_d1_dig", 16'(dig_en), 16'h2);
      run_to(23); check("s5_masked_dig", 16'(dig_en), 16'h0);
                  check("s5_masked_seg", 16'(seg_out), 16'h0);
      run_to(41); blank_mask = '0;
      run_to(42); check("s5_d0_seg", 16'(seg_out), 16'h7E);
      run_to(52); check("s5_d1_seg", 16'(seg_out), 16'h79);
      run_to(72);
`ifdef SEG7_LZ_SUPPRESS_EN
      check("s5_lz_d3", 16'(dig_en), 16'h0);
`else
      check("s5_lz_d3", 16'(dig_en), 16'h8);
`endif
      run_to(80);

      // Scenario 6: asynchronous reset mid-slot with pending full
      do_reset();
      run_to(5);  offer(16'h5A5A);
      run_to(23);
      rst_n = 1'b0;
      #1;
      check("s6_async_dig", 16'(dig_en), 16'h0);
      check("s6_async_ready", 16'(lif.load_ready), 16'd1);
      cycle();
      cycle();
      rst_n = 1'b1;
      cyc = -1;
      run_to(0);  check("s6_fs0", 16'(frame_start), 16'd1);
      run_to(42); check("s6_discard_seg", 16'(seg_out), 16'h7E);
      run_to(50);

      // Randomized traffic with occasional mask changes and resets
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if (!lif.load_valid && $urandom_range(0, 9) == 0) offer(rand_data());
         if ($urandom_range(0, 63) == 0) blank_mask = N'($urandom_range(0, 15));
         if ($urandom_range(0, 999) == 0) do_reset();
         cycle();
      end

      lif.load_valid = 1'b0;
      cycle();
      cycle();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/seg7_scan_ctrl.md
# seg7_scan_ctrl

Time-multiplexed scan controller for a common-segment multi-digit 7-segment display. It owns one shared hex-to-segment decoder and drives the digits in turn. It sequences a per-digit blank/drive cycle to suppress ghosting, and double-buffers the display value through a valid/ready load port so that updates land only at frame boundaries. It sits between any producer of hex values (counters, register views) and the board display pins.

## Interface
- `NUM_DIGITS`, default 4: number of digits scanned; must be 2..8.
- `SLOT_CYC`, default 1000: clock cycles per digit slot.
- `BLANK_CYC`, default 8: leading cycles of each slot with all digits off. Requires 1 <= `BLANK_CYC` < `SLOT_CYC`.
- `clk` input 1: single clock; all state on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `load_valid` input 1: new display value offered.
- `load_ready` output 1: pending buffer empty; transfer occurs when valid && ready.
- `load_data` input 4*`NUM_DIGITS`: nibble i drives digit i; digit 0 is least significant.
- `blank_mask` input `NUM_DIGITS`: bit i=1 forces digit i dark; sampled live each cycle.
- `seg_out` output 7: segments {a,b,c,d,e,f,g}, bit6=a, active-high.
- `dig_en` output `NUM_DIGITS`: one-hot digit enable, active-high.
- `frame_start` output 1: one-cycle pulse marking the first cycle of the digit-0 slot.

## Operation
- State machine has two states:
  - BLANK: `dig_en`=0 and `seg_out`=0 for `BLANK_CYC` cycles, then go to DRIVE.
  - DRIVE: for `SLOT_CYC`-`BLANK_CYC` cycles, then go to BLANK and advance the digit index.
- Digit index runs 0..`NUM_DIGITS`-1 and wraps to 0. The wrap marks a frame boundary.
- In DRIVE for digit i:
  - `dig_en` = 1<<i.
  - `seg_out` = decode(display[i]).
  - If `blank_mask[i]`=1, then `dig_en`=0 and `seg_out`=0.
- Decoder encoding, hex 0..F: 7E 30 6D 79 33 5B 5F 70 7F 7B 77 1F 4E 3D 4F 47.
- Two registers hold the display value: `pending` (with a full flag) and `display`.
  - `load_ready` = !full.
  - An accepted load writes `pending` and sets full.
- Transfer of `pending` into `display`:
  - Occurs on the edge that enters BLANK of digit 0, if full. That edge also clears full.
  - If a load is accepted on that same edge while full=0, `load_data` goes directly to `display` and full stays 0.
- Mid-frame loads never alter `display`. At most one pending value exists.

## Timing
- Reset values:
  - Outputs: `seg_out`=0, `dig_en`=0, `load_ready`=1, `frame_start`=0.
  - Internal: state BLANK, digit index 0, slot counter 0, `display`=0, full=0.
- The first cycle after `rst_n` rises is the BLANK cycle 0 of digit 0, with `frame_start`=1.
- Outputs are registered. They reflect the state and counter of the current cycle with no extra latency.
- One frame lasts `NUM_DIGITS`*`SLOT_CYC` cycles.
- Load-to-visible latency: from acceptance to the next frame boundary, plus `BLANK_CYC` cycles.
- `load_ready` drops the cycle after acceptance. It rises the cycle after the transfer edge.
- Asserting `rst_n` low mid-slot immediately forces all outputs to their reset values and discards `pending`.

## Configuration
- Macro: `SEG7_LZ_SUPPRESS_EN`.
- Defined: leading-zero suppression is on.
  - Digits above the most significant nonzero nibble of `display` are blanked, the same as a `blank_mask` bit.
  - Digit 0 is never suppressed.
- Undefined: all digits display their nibble, and there is no suppression logic.

## Structure
- Shared package `seg7_pkg` holds:
  - The state enum {BLANK, DRIVE}.
  - The 16-entry segment constant table.
  - The segment bit-order constants.
- Sub-module `seg7_hex_decode`: purely combinational nibble-to-segment decoder, instantiated once in the controller.

## Test plan
All scenarios use `NUM_DIGITS`=4, `SLOT_CYC`=10, `BLANK_CYC`=2 unless noted.

1. Reset, then no load:
   - `frame_start` pulses at cycle 0, 40 and 80.
   - `dig_en` sequence per slot is 0,0 then 0001 for 8 cycles, then 0010, 0100, 1000.
   - `seg_out`=7E in every DRIVE cycle.
2. Load 16'h1A2F at cycle 5:
   - `display` is unchanged until cycle 40.
   - From cycle 42, digit 0 shows 47, then digit 1 shows 6D, digit 2 shows 77, digit 3 shows 30.
   - `load_ready` is low for cycles 6..40.
3. Two loads: 16'h1111 accepted at cycle 5, then 16'h2222 offered at cycle 10:
   - The second load is held off (`load_ready`=0) until cycle 41.
   - The next frame shows 1111; the frame after that shows 2222.
4. Load accepted on the boundary edge (cycle 39→40) with `pending` empty:
   - The value displays from cycle 42.
   - `load_ready` stays 1.
5. Blanking and suppression:
   - `blank_mask`=4'b0100: digit 2 slot has `dig_en`=0 and `seg_out`=0.
   - With `SEG7_LZ_SUPPRESS_EN` defined and `display`=16'h0030: digits 2 and 3 are dark and digit 0 shows 7E.
6. `rst_n` low at cycle 23 (digit 2 DRIVE) with `pending` full:
   - Outputs go to 0 asynchronously.
   - After release, `display`=0, `load_ready`=1, and `frame_start` pulses on the first cycle.
